// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared states and framing constants for the serial program loader
package program_loader_pkg;
    typedef enum logic [2:0] {IDLE, COUNT, DATA, DONE, ERROR} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int BYTES_PER_WORD = 4;
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + (index << 2);
    endfunction
endpackage

// File: rtl/program_loader_packer.sv
// byte_to_word_packer: big-endian assembly of serial bytes into 32-bit words
module byte_to_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [23:0] shift;
    logic [1:0]  count;
    logic        take;
    // the fourth byte completes the word combinationally so the top can register the write on the same edge
    always_comb begin
        take = en && byte_valid;
        word_valid = take && count == 2'(BYTES_PER_WORD - 1);
        word = {shift, byte_data};
    end
    // shift in accepted bytes; the counter wraps to 0 after each full word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= '0;
            count <= '0;
        end else if (clr) begin
            shift <= '0;
            count <= '0;
        end else if (take) begin
            shift <= {shift[15:0], byte_data};
            count <= count + 2'd1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed program over a byte link and writes it into program memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int IW = $clog2(MEMORY_DEPTH) + 1;
    state_t        state;
    logic [IW-1:0] word_count;
    logic [IW-1:0] word_index;
    logic          en;
    logic          clr;
    logic          word_valid;
    logic [31:0]   word;
    // packing stops once the last word has been written so stray bytes cannot start another word
    always_comb begin
        en = state == DATA && word_index != word_count;
        clr = state != DATA;
    end
    byte_to_word_packer packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .en         (en),
        .byte_valid (byte_valid_i),
        .byte_data  (byte_data_i),
        .word_valid (word_valid),
        .word       (word)
    );
    // load sequencer with registered status outputs; DONE follows the cycle of the final write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mem_write_o <= 1'b0;
            mem_address_o <= BASE_ADDR;
            mem_data_o <= '0;
            cpu_reset_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            error_o <= 1'b0;
            word_count <= '0;
            word_index <= '0;
        end else begin
            mem_write_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (byte_valid_i && byte_data_i == SYNC_BYTE) begin
                        state <= COUNT;
                        busy_o <= 1'b1;
                        done_o <= 1'b0;
                        cpu_reset_o <= 1'b0;
                    end
                end
                COUNT: begin
                    if (byte_valid_i) begin
                        if (byte_data_i == 8'h00 || int'(byte_data_i) > MEMORY_DEPTH) begin
                            state <= ERROR;
                            busy_o <= 1'b0;
                            error_o <= 1'b1;
                        end else begin
                            state <= DATA;
                            word_count <= IW'(byte_data_i);
                            word_index <= '0;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_write_o <= 1'b1;
                        mem_address_o <= word_addr(BASE_ADDR, 32'(word_index));
                        mem_data_o <= word;
                        word_index <= word_index + IW'(1);
                    end else if (mem_write_o && word_index == word_count) begin
                        state <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        cpu_reset_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: vector table plus write scoreboard for program_loader
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        busy;
        logic        done;
        logic        err;
        logic        cpu;
        logic        push;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_wr_t;

    vec_t    vt[$];
    exp_wr_t sb[$];
    exp_wr_t e;
    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      n_writes = 0;

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .byte_valid_i  (byte_valid_i),
        .byte_data_i   (byte_data_i),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .cpu_reset_o   (cpu_reset_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write_o === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", mem_address_o, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", mem_address_o, e.addr);
                check("wr_data", mem_data_o, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic vec_t row_b(input logic [7:0] d, input logic [3:0] f);
        return '{1'b0, 1'b1, d, f[3], f[2], f[1], f[0], 1'b0, 32'h0, 32'h0};
    endfunction

    function automatic vec_t row_i(input logic [3:0] f);
        return '{1'b0, 1'b0, 8'h5A, f[3], f[2], f[1], f[0], 1'b0, 32'h0, 32'h0};
    endfunction

    function automatic vec_t row_w(input logic [7:0] d, input logic [31:0] a, input logic [31:0] w);
        return '{1'b0, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a, w};
    endfunction

    function automatic vec_t row_r();
        return '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        byte_valid_i = v;
        byte_data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        byte_valid_i = 1'b0;
        reset = 1'b0;
        #2;
        check("rst_write", mem_write_o, 0);
        check("rst_addr", mem_address_o, 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_cpu", cpu_reset_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", error_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] wd;
        int          base;
        vt.push_back(row_r());
        vt.push_back(row_b(8'hA5, 4'b1000));
        vt.push_back(row_b(8'h02, 4'b1000));
        vt.push_back(row_b(8'h20, 4'b1000));
        vt.push_back(row_b(8'h08, 4'b1000));
        vt.push_back(row_b(8'h00, 4'b1000));
        vt.push_back(row_w(8'h05, 32'h0, 32'h2008_0005));
        vt.push_back(row_b(8'h21, 4'b1000));
        vt.push_back(row_b(8'h09, 4'b1000));
        vt.push_back(row_b(8'h00, 4'b1000));
        vt.push_back(row_w(8'h07, 32'h4, 32'h2109_0007));
        vt.push_back(row_i(4'b0101));
        vt.push_back(row_b(8'h33, 4'b0101));
        vt.push_back(row_b(8'hA5, 4'b1000));
        vt.push_back(row_b(8'h01, 4'b1000));
        vt.push_back(row_b(8'hDE, 4'b1000));
        vt.push_back(row_i(4'b1000));
        vt.push_back(row_b(8'hAD, 4'b1000));
        vt.push_back(row_b(8'hBE, 4'b1000));
        vt.push_back(row_w(8'hEF, 32'h0, 32'hDEAD_BEEF));
        vt.push_back(row_i(4'b0101));
        vt.push_back(row_r());
        vt.push_back(row_b(8'h00, 4'b0000));
        vt.push_back(row_b(8'hFF, 4'b0000));
        vt.push_back(row_b(8'hA5, 4'b1000));
        vt.push_back(row_b(8'h00, 4'b0010));
        vt.push_back(row_b(8'hA5, 4'b0010));
        vt.push_back(row_b(8'h01, 4'b0010));
        vt.push_back(row_i(4'b0010));
        vt.push_back(row_r());
        vt.push_back(row_b(8'hA5, 4'b1000));
        vt.push_back(row_b(8'h21, 4'b0010));
        vt.push_back(row_r());
        vt.push_back(row_b(8'hA5, 4'b1000));
        vt.push_back(row_b(8'h01, 4'b1000));
        vt.push_back(row_b(8'h12, 4'b1000));
        vt.push_back(row_b(8'h34, 4'b1000));
        vt.push_back(row_r());
        vt.push_back(row_b(8'h56, 4'b0000));
        vt.push_back(row_b(8'h78, 4'b0000));
        vt.push_back(row_i(4'b0000));
        @(posedge clk);
        #1;
        foreach (vt[k]) begin
            if (vt[k].rst) begin
                do_reset();
            end else begin
                if (vt[k].push) sb.push_back('{vt[k].addr, vt[k].data, cyc + 1});
                step(vt[k].v, vt[k].d);
                check($sformatf("busy[%0d]", k), busy_o, vt[k].busy);
                check($sformatf("done[%0d]", k), done_o, vt[k].done);
                check($sformatf("err[%0d]", k), error_o, vt[k].err);
                check($sformatf("cpu_reset[%0d]", k), cpu_reset_o, vt[k].cpu);
            end
        end
        do_reset();
        base = n_writes;
        step(1'b1, 8'hA5);
        step(1'b1, 8'h20);
        check("full_busy", busy_o, 1);
        for (int w = 0; w < 32; w++) begin
            wd = $urandom;
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 8'(($urandom)));
                if (j == 3) sb.push_back('{32'(w * 4), wd, cyc + 1});
                step(1'b1, wd[31 - 8 * j -: 8]);
            end
        end
        check("full_last_addr", mem_address_o, 32'h7C);
        step(1'b0, 8'h00);
        check("full_done", done_o, 1);
        check("full_cpu_reset", cpu_reset_o, 1);
        check("full_writes", n_writes - base, 32);
        repeat (2) step(1'b0, 8'h00);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning program memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address written for word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port byte_valid_i, input, 1 bit: byte_data_i carries a byte this cycle.
REQ-006 SHALL have port byte_data_i, input, 8 bits: serial-link byte.
REQ-007 SHALL have port mem_write_o, output, 1 bit: program-memory write strobe, one cycle per word.
REQ-008 SHALL have port mem_address_o, output, 32 bits: word-aligned byte address.
REQ-009 SHALL have port mem_data_o, output, 32 bits: instruction word to write.
REQ-010 SHALL have port cpu_reset_o, output, 1 bit: active-low reset for the processor; low while loading.
REQ-011 SHALL have port busy_o, output, 1 bit: high in COUNT and DATA.
REQ-012 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-013 SHALL have port error_o, output, 1 bit: high in ERROR.

Function
REQ-014 SHALL implement states IDLE, COUNT, DATA, DONE, ERROR; a byte is consumed only on a cycle with byte_valid_i=1.
REQ-015 SHALL, in IDLE, move to COUNT on a byte equal to 8'hA5 and ignore every other byte.
REQ-016 SHALL, in COUNT, latch the byte as word count N; N=0 or N>MEMORY_DEPTH -> ERROR, else -> DATA with word index 0 and byte index 0.
REQ-017 SHALL, in DATA, assemble 4 bytes big-endian (first byte -> bits [31:24]).
REQ-018 SHALL assert mem_write_o for exactly one cycle, the cycle after the 4th byte of a word is consumed, with mem_data_o = assembled word and mem_address_o = BASE_ADDR + 4*word_index.
REQ-019 SHALL accept the next word's first byte on the same cycle mem_write_o is high (back-to-back bytes every cycle, no stalls, no byte loss).
REQ-020 SHALL increment word_index by 1 after each write; after write N-1, next state is DONE.
REQ-021 SHALL hold mem_address_o and mem_data_o stable except on the cycle a new write is registered; mem_write_o=0 outside those cycles.
REQ-022 SHALL drive cpu_reset_o=0 in IDLE, COUNT, DATA and ERROR, and cpu_reset_o=1 from the first cycle in DONE.
REQ-023 SHALL, in DONE, on byte 8'hA5 go to COUNT (cpu_reset_o=0 next cycle); other bytes ignored.
REQ-024 SHALL stay in ERROR, ignoring all bytes, until reset.
REQ-025 SHALL use word_index of width clog2(MEMORY_DEPTH)+1 bits so index MEMORY_DEPTH is representable; address arithmetic is 32-bit modulo 2^32.
REQ-026 SHALL, when byte_valid_i is low mid-word, retain partial word and byte index indefinitely (no timeout).

Reset
REQ-027 SHALL, on reset=0 asynchronously: state=IDLE, mem_write_o=0, mem_address_o=BASE_ADDR, mem_data_o=0, cpu_reset_o=0, busy_o=0, done_o=0, error_o=0, all counters 0.
REQ-028 SHALL, on reset asserted mid-DATA, abandon the partial word without issuing a write, and require a new 8'hA5 after release.
REQ-029 SHALL leave the processor held in reset (cpu_reset_o=0) after reset release until a load completes.

Structure
REQ-030 SHALL place the state enumeration, SYNC_BYTE=8'hA5 and BYTES_PER_WORD=4 in a shared loader package.
REQ-031 SHALL implement byte assembly (shift register + 2-bit byte counter + word-complete pulse) as sub-module byte_to_word_packer; FSM, address counter and outputs stay in program_loader.

Verification
REQ-032 SHALL cover: A5, 02, 20 08 00 05, 21 09 00 07 on consecutive cycles -> writes 0x20080005@0x0 and 0x21090007@0x4 one cycle after each 4th byte; cpu_reset_o=1 and done_o=1 the cycle after the second write.
REQ-033 SHALL cover: bytes 00 FF A5 then 00 -> first two ignored, error_o=1 after 00, no write, cpu_reset_o stays 0; further A5 ignored.
REQ-034 SHALL cover: A5, 21 (33 > 32) -> ERROR, no write.
REQ-035 SHALL cover: A5, 20 then 128 data bytes with random valid gaps -> exactly 32 writes, last at 0x7C, then DONE.
REQ-036 SHALL cover: A5, 01, 12 34 then reset pulse low, release, then 56 78 -> no write, state IDLE, cpu_reset_o=0.
REQ-037 SHALL cover: after DONE, A5, 01, DE AD BE EF -> cpu_reset_o drops the cycle after A5, write 0xDEADBEEF@0x0, returns to DONE.
